id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data and PC width.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 if_valid / if_instr / if_pc  input  1 / 32 / XLEN  IF/ID register contents: valid, instruction, PC.
REQ-005 stall_if  output  1  hold request to the IF/ID register and the PC.
REQ-006 flush  input  1  redirect from EX; kill the instruction now in decode.
REQ-007 rf_addr_rs1 / rf_addr_rs2  output  5 / 5  register file read addresses.
REQ-008 rf_data_rs1 / rf_data_rs2  input  XLEN / XLEN  register file read data, combinational from the addresses.
REQ-009 wb_we / wb_rd / wb_data  input  1 / 5 / XLEN  writeback port, driven the same as the register file write port.
REQ-010 ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_ctrl, ex_illegal  outputs  1, XLEN, XLEN, XLEN, XLEN, 5, 5, 5, 4, 8, 1  ID/EX register contents.

Function
REQ-011 rf_addr_rs1 SHALL equal if_instr[19:15] combinationally.
REQ-012 rf_addr_rs2 SHALL equal if_instr[24:20] combinationally.
REQ-013 The decoder SHALL support the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-014 Any other opcode, or an invalid funct3/funct7 combination, SHALL produce ex_illegal=1 and ex_ctrl=0.
REQ-015 ex_ctrl bits SHALL be, in package order: reg_write, mem_read, mem_write, branch, jump, alu_src_imm, alu_src_pc, and reserved (driven 0).
REQ-016 Immediates SHALL be generated for the I, S, B, U and J formats and sign-extended to XLEN; R-type SHALL give ex_imm=0.
REQ-017 Writeback bypass: for each source rsN, if wb_we=1, wb_rd!=0 and wb_rd==rsN, the operand SHALL be wb_data; otherwise it SHALL be rf_data_rsN.
REQ-018 Source x0 SHALL always yield 0, regardless of the bypass and of rf data.
REQ-019 rs1 is used by all supported opcodes except LUI, AUIPC and JAL; rs2 is used by OP, STORE and BRANCH only.
REQ-020 Load-use hazard = if_valid and ex_valid and ex_ctrl.mem_read and ex_rd!=0 and ex_rd equal to a used source of the decoding instruction.
REQ-021 stall_if SHALL equal hazard and not flush, combinationally.
REQ-022 Normal capture: when if_valid=1, with no hazard and no flush, all ex_* outputs SHALL load the decoded values at the next edge (latency 1 cycle).
REQ-023 When if_valid=0, the block SHALL load a bubble.
REQ-024 Hazard without flush: the block SHALL load a bubble (ex_valid=0, ex_ctrl=0); the held instruction re-decodes next cycle and then issues, since the hazard clears.
REQ-025 A flush SHALL take priority over a hazard: the block loads a bubble and stall_if=0.
REQ-026 Bubble rule: ex_valid and ex_ctrl SHALL be 0 and ex_illegal SHALL be 0; other data fields are don't-care, but the bench expects them to hold their prior value.

Reset
REQ-027 While rst_n=0, all ex_* outputs SHALL be 0, taking effect immediately and independent of clk.
REQ-028 Consequently stall_if SHALL be 0 while in reset.
REQ-029 Reset asserted mid-stall SHALL discard the stalled state.
REQ-030 The first edge after rst_n rises SHALL capture normally.

Structure
REQ-031 Shared package riscv_pkg SHALL hold: opcode constants, the alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), ex_ctrl bit indices and the imm_type_t enum.
REQ-032 The block SHALL contain one sub-module, imm_gen, which is combinational: instruction and imm_type in, XLEN-bit immediate out.

Verification
REQ-033 addi x1,x0,5 (0x00500093) at pc 0x100 -> next cycle ex_valid=1, ex_pc=0x100, ex_rd=1, ex_imm=5, ex_alu_op=ADD, reg_write=1, alu_src_imm=1.
REQ-034 add x4,x3,x0 (0x00018233) with rf_data_rs1=0, wb_we=1, wb_rd=3, wb_data=0xDEADBEEF -> ex_rs1_data=0xDEADBEEF.
REQ-035 lw x5,0(x2) (0x00012283) then add x6,x5,x1 (0x00128333) -> stall_if=1 for exactly 1 cycle, one bubble, then add issues with ex_rs1=5.
REQ-036 Same load-use sequence with flush=1 in the hazard cycle -> stall_if=0 and ex_valid=0 next cycle.
REQ-037 wb_we=1, wb_rd=0, wb_data=0x1234, rf_data_rs1=0x55 while decoding a rs1=x0 instruction -> ex_rs1_data=0.
REQ-038 Instruction 0xFFFFFFFF -> ex_illegal=1, ex_ctrl=0.
REQ-039 Assert rst_n=0 during a stall -> all ex_* outputs 0 and stall_if=0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, ALU ops, control bit indices and immediate formats
package riscv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;
  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_BRANCH      = 3;
  localparam int CTRL_JUMP        = 4;
  localparam int CTRL_ALU_SRC_IMM = 5;
  localparam int CTRL_ALU_SRC_PC  = 6;
  localparam int CTRL_RESERVED    = 7;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
  // alt selects SUB/SRA over ADD/SRL (funct7[5])
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction, sign-extended to XLEN
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm
);
  logic [31:0] raw;
  logic        unused;
  assign unused = ^instr[6:0];
  always_comb begin
    raw = '0;
    case (imm_type)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end
  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, writeback bypass, load-use stall and ID/EX pipeline register
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            stall_if,
  input  logic            flush,
  output logic [4:0]      rf_addr_rs1,
  output logic [4:0]      rf_addr_rs2,
  input  logic [XLEN-1:0] rf_data_rs1,
  input  logic [XLEN-1:0] rf_data_rs2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic [7:0]      ex_ctrl,
  output logic            ex_illegal
);
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd;
  logic [7:0]      ctrl;
  alu_op_t         alu;
  imm_type_t       imm_type;
  logic            illegal, use_rs1, use_rs2, hazard;
  logic [XLEN-1:0] imm, op1, op2;
  assign opcode = if_instr[6:0];
  assign rd = if_instr[11:7];
  assign f3 = if_instr[14:12];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign f7 = if_instr[31:25];
  assign rf_addr_rs1 = rs1;
  assign rf_addr_rs2 = rs2;
  always_comb begin
    ctrl = '0;
    alu = ALU_ADD;
    imm_type = IMM_NONE;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        alu = ALU_PASS_B;
        imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        ctrl[CTRL_ALU_SRC_PC] = 1'b1;
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_JUMP] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        ctrl[CTRL_ALU_SRC_PC] = 1'b1;
        imm_type = IMM_J;
      end
      OPC_JALR: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_JUMP] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        imm_type = IMM_I;
        use_rs1 = 1'b1;
        illegal = f3 != 3'd0;
      end
      OPC_BRANCH: begin
        ctrl[CTRL_BRANCH] = 1'b1;
        alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        imm_type = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_MEM_READ] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        imm_type = IMM_I;
        use_rs1 = 1'b1;
        illegal = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        imm_type = IMM_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = f3[2] || f3 == 3'd3;
      end
      OPC_OP_IMM: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        alu = alu_from_f3(f3, f3 == 3'd5 && f7[5]);
        imm_type = IMM_I;
        use_rs1 = 1'b1;
        illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_OP: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        alu = alu_from_f3(f3, f7[5]);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end
  imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(if_instr), .imm_type(imm_type), .imm(imm));
  // x0 reads as zero even if a stray writeback targets it
  assign op1 = rs1 == 5'd0 ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_data_rs1;
  assign op2 = rs2 == 5'd0 ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_data_rs2;
  assign hazard = if_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] && ex_rd != 5'd0 &&
                  ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
  assign stall_if = hazard && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd <= '0;
      ex_alu_op <= '0;
      ex_ctrl <= '0;
      ex_illegal <= 1'b0;
    end else if (if_valid && !hazard && !flush) begin
      ex_valid <= 1'b1;
      ex_pc <= if_pc;
      ex_rs1_data <= op1;
      ex_rs2_data <= op2;
      ex_imm <= imm;
      ex_rs1 <= rs1;
      ex_rs2 <= rs2;
      ex_rd <= rd;
      ex_alu_op <= alu;
      ex_ctrl <= ctrl;
      ex_illegal <= illegal;
    end else begin
      ex_valid <= 1'b0;
      ex_ctrl <= '0;
      ex_illegal <= 1'b0;
    end
  end
endmodule
